// File: rtl/sramlike_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter and the bridge behind it:
// grant-id encodings, transfer size encodings, arbiter state type and
// width helpers for the owner FIFO.
package sramlike_arbiter_pkg;

    // Grant identifiers (also the value stored in the owner FIFO)
    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    // Transfer size encodings on the size buses
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Arbiter states: IDLE means no grant held, GRANT means gnt_id owns the slave port
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Pointer width for a DEPTH-entry FIFO (at least one bit so DEPTH=1 still has a pointer)
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    // Occupancy counter width: must hold the value DEPTH itself
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

endpackage

// File: rtl/sramlike_arbiter_if.sv
// One sram-like bus: request side (req/wr/size/addr/wdata) driven by the
// master, handshake/response side (addr_ok/data_ok/rdata) driven by the slave.
interface sramlike_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sramlike_arbiter_owner_fifo.sv
// In-order owner FIFO: one bit per accepted transaction recording which
// master issued it, so responses can be steered back in issue order.
module sramlike_arbiter_owner_fifo
    import sramlike_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  logic          din_i,
    input  logic          pop_i,
    output logic          head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int unsigned PW = ptr_width(DEPTH);

    logic          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Advance a pointer, wrapping modulo DEPTH (DEPTH need not fill the pointer range)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign empty_o   = (count_q == CW'(0));
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Next pointer and occupancy values; simultaneous push/pop keeps the count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/sramlike_arbiter.sv
// Two-master sram-like arbiter in front of the CPU AXI bridge. m0 (data)
// has priority, m1 (instruction) is protected from starvation. Every
// accepted request records its owner in an in-order FIFO so that data_ok
// and rdata are routed back to the right master.
module sramlike_arbiter
    import sramlike_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               resetn,
    sramlike_arbiter_if.slave  m0_bus,
    sramlike_arbiter_if.slave  m1_bus,
    sramlike_arbiter_if.master s_bus,
    output logic               err_spurious_o
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e    state_q, state_d;
    logic          gnt_id_q, gnt_id_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_q, err_d;

    logic          gnt_vld_s;
    logic          sel_req_s;
    logic          s_req_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          spurious_s;
    logic          any_req_s;
    logic          has_room_s;
    logic          m1_wins_s;
    logic          fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;

    assign gnt_vld_s  = (state_q == ST_GRANT);
    assign sel_req_s  = (gnt_id_q == GNT_M1) ? m1_bus.req : m0_bus.req;
    assign s_req_s    = gnt_vld_s & sel_req_s;
    assign accept_s   = s_req_s & s_bus.addr_ok;
    assign push_s     = accept_s & ~fifo_full_s;
    assign pop_s      = s_bus.data_ok & ~fifo_empty_s;
    assign spurious_s = s_bus.data_ok & fifo_empty_s;
    assign any_req_s  = m0_bus.req | m1_bus.req;
    // Registered count: a pop in this cycle only frees a slot for the next arbitration
    assign has_room_s = (fifo_count_s < CW'(DEPTH));
    assign m1_wins_s  = m1_bus.req & (~m0_bus.req | (starve_q == SW'(STARVE_LIMIT)));

    sramlike_arbiter_owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push_s),
        .din_i   (gnt_id_q),
        .pop_i   (pop_s),
        .head_o  (fifo_head_s),
        .count_o (fifo_count_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    // Arbitration and grant-release decisions plus starvation bookkeeping
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        starve_d = starve_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s && has_room_s) begin
                    state_d = ST_GRANT;
                    if (m1_wins_s) begin
                        gnt_id_d = GNT_M1;
                        starve_d = '0;
                    end else begin
                        gnt_id_d = GNT_M0;
                        if (m1_bus.req) begin
                            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q
                                                                       : starve_q + SW'(1);
                        end else begin
                            starve_d = '0;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A master dropping req while granted keeps the grant; s_req simply follows it
                if (accept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Spurious-response flag is sticky until reset
    always_comb begin
        err_d = err_q | spurious_s;
    end

    // Grant FSM, starvation counter and error flag registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            gnt_id_q <= GNT_M0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Slave-side request mux; forced to zero whenever no grant is held
    always_comb begin
        s_bus.req   = s_req_s;
        s_bus.wr    = 1'b0;
        s_bus.size  = 2'b00;
        s_bus.addr  = 32'h0000_0000;
        s_bus.wdata = 32'h0000_0000;
        if (gnt_vld_s && (gnt_id_q == GNT_M1)) begin
            s_bus.wr    = m1_bus.wr;
            s_bus.size  = m1_bus.size;
            s_bus.addr  = m1_bus.addr;
            s_bus.wdata = m1_bus.wdata;
        end else if (gnt_vld_s) begin
            s_bus.wr    = m0_bus.wr;
            s_bus.size  = m0_bus.size;
            s_bus.addr  = m0_bus.addr;
            s_bus.wdata = m0_bus.wdata;
        end else begin
            s_bus.wr    = 1'b0;
            s_bus.size  = 2'b00;
            s_bus.addr  = 32'h0000_0000;
            s_bus.wdata = 32'h0000_0000;
        end
    end

    // Master-side handshakes: addr_ok only to the granted master, data_ok to the FIFO head owner
    always_comb begin
        m0_bus.addr_ok = accept_s & (gnt_id_q == GNT_M0);
        m1_bus.addr_ok = accept_s & (gnt_id_q == GNT_M1);
        m0_bus.data_ok = pop_s & (fifo_head_s == GNT_M0);
        m1_bus.data_ok = pop_s & (fifo_head_s == GNT_M1);
        m0_bus.rdata   = s_bus.rdata;
        m1_bus.rdata   = s_bus.rdata;
    end

    assign err_spurious_o = err_q;

endmodule

// File: doc/sramlike_arbiter.md
Name: sramlike_arbiter

Overview:
- Shares one sram-like slave port, in front of the CPU AXI bridge, between two sram-like masters: m0 (data side, high priority) and m1 (instruction side).
- Grants one request at a time.
- Records the owner of every accepted transaction in an in-order owner FIFO.
- Routes each data_ok/rdata back to the owning master.
- Caps outstanding transactions at DEPTH and prevents m1 starvation.

Parameters:
DEPTH, 2, max accepted-but-not-completed transactions (owner FIFO depth, power of 2, >=1)
STARVE_LIMIT, 4, consecutive m0 grants while m1 waits before m1 is forced to win

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
m0_req  input  1  data master request, held until m0_addr_ok
m0_wr  input  1  write=1 / read=0
m0_size  input  2  0=byte,1=half,2=word
m0_addr  input  32  address
m0_wdata  input  32  write data
m0_addr_ok  output  1  request accepted
m0_data_ok  output  1  response for oldest m0 transaction
m0_rdata  output  32  read data
m1_req, m1_wr, m1_size, m1_addr, m1_wdata, m1_addr_ok, m1_data_ok, m1_rdata  (same directions/widths/meaning for instruction master)
s_req  output  1  request to bridge
s_wr  output  1  muxed wr
s_size  output  2  muxed size
s_addr  output  32  muxed addr
s_wdata  output  32  muxed wdata
s_addr_ok  input  1  bridge accepted request
s_data_ok  input  1  bridge completed oldest transaction
s_rdata  input  32  bridge read data
err_spurious  output  1  sticky: s_data_ok seen with FIFO empty

Behaviour:
- Reset (resetn=0 at posedge):
  - Clears gnt_vld, gnt_id, FIFO pointers, count, starve counter, err_spurious.
  - All outputs 0 in the following cycle; rdata outputs are pass-through.
  - In-flight transactions are discarded; a mid-operation reset needs no drain.
- State: IDLE (gnt_vld=0) and GRANT (gnt_vld=1, gnt_id in {0,1}).
- IDLE -> GRANT:
  - Fires at the posedge where (m0_req|m1_req) and count<DEPTH.
  - Winner: m1 if m1_req and (!m0_req or starve_cnt==STARVE_LIMIT); otherwise m0.
  - One-cycle arbitration latency: s_req is never asserted in the cycle a master first raises req.
- GRANT:
  - s_req = m[gnt_id]_req; s_wr/size/addr/wdata are combinational muxes on gnt_id.
  - m[gnt_id]_addr_ok = s_addr_ok & s_req; the other master's addr_ok = 0.
  - No request reaches the slave port outside GRANT.
- GRANT -> IDLE: at the posedge where s_req & s_addr_ok.
  - Pushes gnt_id into the owner FIFO.
  - Next arbitration uses the updated count, so back-to-back grants have one idle cycle.
- Starve counter:
  - Increments on an m0 grant while m1_req=1, saturating at STARVE_LIMIT.
  - Clears on any m1 grant, or on any m0 grant while m1_req=0.
- Response routing:
  - m0_data_ok = s_data_ok & !empty & head==0; m1 likewise for head==1.
  - Combinational, 0-cycle.
  - m0_rdata = m1_rdata = s_rdata.
  - On s_data_ok & !empty: pop.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Full: with count==DEPTH, stay in IDLE and give no addr_ok. A pop in the same cycle does not unblock until the next cycle (registered count).
- Empty: s_data_ok with count==0 sets err_spurious (sticky until reset), routes to no master, and leaves pointers unchanged.
- Pointer wrap: log2(DEPTH) bits wrapping modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
- A master dropping req while granted is a protocol violation: the arbiter holds the grant and s_req follows the (now 0) req.

Decomposition:
- Shared package: grant-id constants (GNT_M0=0, GNT_M1=1) and size encodings (SIZE_B/H/W); both are reused by the bridge.
- One natural sub-module: owner_fifo (1-bit-wide, DEPTH-entry synchronous FIFO with push/pop/head/count/empty/full).

Test Plan:
1. m0 read only, addr 0x1000; bridge addr_ok 2 cycles after s_req, data_ok later with rdata 0xDEADBEEF -> m0_addr_ok once, m0_data_ok once with 0xDEADBEEF, m1_* stay 0.
2. m0_req and m1_req both raised in the same cycle -> m0 granted first (s_addr = m0 addr), m1 granted after m0's addr_ok plus one idle cycle.
3. m0_req held continuously with m1_req waiting -> grants m0,m0,m0,m0,m1 (STARVE_LIMIT=4), starve counter then clears.
4. DEPTH=2: accept two requests (m0 then m1) with bridge withholding data_ok -> third request gets no s_req. First data_ok goes to m0, second to m1; the third request is granted on the cycle after the first pop.
5. Push and pop in the same cycle at count=1 -> count stays 1, order preserved, correct routing.
6. Reset asserted while 1 transaction is outstanding, then s_data_ok pulsed -> no m*_data_ok, err_spurious=1.
